timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Memory-mapped controller for the system millisecond timer on the RISC32-SC data bus.
- Generates the count tick from a programmable prescaler and sequences the count register in one-shot or periodic mode.
- Compares the count against a software-set value and raises a maskable interrupt on match.
- Register reads are combinational so the single-cycle CPU can complete a load in one cycle.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1000, default tick rate. PRESCALE reset value = CLK_HZ/TICK_HZ-1 = 49999.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- SEL  input  1  bus select for this block.
- WE  input  1  write enable, qualified by SEL.
- Addr  input  3  word index (CPU address bits [4:2]).
- Di  input  32  write data.
- Do  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request = MATCH & IE.
- TICK  output  1  one-cycle prescaler tick pulse.

Behaviour:
- Register map:
  - 0 CTRL: [0] EN, [1] MODE (0 = one-shot, 1 = periodic), [2] IE. Other bits read as 0.
  - 1 PRESCALE.
  - 2 COUNT.
  - 3 COMPARE.
  - 4 STATUS: [0] MATCH, write-1-to-clear.
  - 5-7: read 0, writes ignored.
- Reset (RESET=0, async): CTRL=0, PRESCALE=49999, COUNT=0, COMPARE=0, MATCH=0, PCNT=0. Outputs: IRQ=0, TICK=0, Do reflects the reset registers.
- Writes: a write occurs when SEL&WE at a rising edge and takes effect on that edge. Do is 0 when SEL=0.
- Prescaler (internal PCNT, 32-bit):
  - While EN=1: if PCNT==PRESCALE then TICK=1 and PCNT<=0, else PCNT<=PCNT+1.
  - While EN=0: PCNT holds and TICK=0.
  - PRESCALE=0 gives TICK every cycle while EN=1.
  - TICK is combinational from PCNT, PRESCALE and EN.
- On each TICK, next = COUNT+1 (32-bit, wraps):
  - If next != COMPARE: COUNT<=next.
  - If next == COMPARE: MATCH<=1. Periodic mode: COUNT<=0. One-shot mode: COUNT<=next and EN<=0.
- COMPARE=0: a match occurs only on the wrap from 0xFFFFFFFF.
- Effective states:
  - IDLE: EN=0.
  - RUN: EN=1.
  - DONE: one-shot matched. EN=0, COUNT holds the COMPARE value, MATCH=1.
  - Transitions: DONE->RUN on a CTRL write with EN=1. Any state->IDLE on a CTRL write with EN=0.
- Write to COUNT: loads Di, clears PCNT to 0, and suppresses any tick increment on that edge.
- Write to PRESCALE: loads Di and clears PCNT to 0.
- Simultaneous events:
  - CTRL write on the same edge as a one-shot match: the written EN wins. MATCH still sets.
  - STATUS W1C on the same edge as a new match: set wins, MATCH=1.
  - COUNT write during a tick: the write wins and MATCH is not set.
- Latency: a match on edge N gives IRQ=1 after edge N (IE=1). IRQ drops in the cycle after the W1C edge.
- RESET asserted mid-count returns all state to reset values immediately, with no clock needed.

Test Plan:
- Reset: hold RESET=0 with the clock running, then release → Do at Addr1 = 49999, all other registers 0, IRQ=0, TICK=0.
- Periodic mode:
  - Setup: PRESCALE=4, COMPARE=3, CTRL=0b111.
  - Response: TICK every 5 cycles; COUNT sequence 1,2,0,1,2,0; MATCH and IRQ rise at the third tick and stay high.
  - W1C of STATUS=1 → IRQ=0 on the next cycle.
- One-shot mode:
  - Setup: PRESCALE=0, COMPARE=10, CTRL=0b101.
  - Response: after 10 cycles COUNT=10, EN reads 0, TICK stays 0, IRQ=1. Rewriting CTRL=0b101 restarts counting from 10.
- Wrap:
  - Setup: COUNT=0xFFFFFFFE, COMPARE=0, PRESCALE=0, MODE=1, EN=1.
  - Response: COUNT reads 0xFFFFFFFF, then a match sets MATCH and COUNT=0.
- Collisions:
  - Write COUNT=7 on the exact tick edge → COUNT=7, MATCH=0.
  - W1C on a match edge → MATCH=1.
- Async reset: assert RESET=0 mid-run for 5 ns between clock edges → registers clear immediately. After release, counting resumes only once EN is rewritten.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// timer_ctrl_if
// Data-bus slave port of the system millisecond timer.
//   SEL  : bus select for the timer block
//   WE   : write enable, qualified by SEL
//   Addr : word index (CPU address bits [4:2])
//   Di   : write data
//   Do   : read data, combinational from Addr (0 when not selected)
// master drives the request side (CPU / testbench), slave is the timer.
// ----------------------------------------------------------------------------
interface timer_ctrl_if;
    logic        SEL;
    logic        WE;
    logic [2:0]  Addr;
    logic [31:0] Di;
    logic [31:0] Do;

    modport master (output SEL, output WE, output Addr, output Di, input  Do);
    modport slave  (input  SEL, input  WE, input  Addr, input  Di, output Do);
endinterface

// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
// Memory-mapped controller for the system millisecond timer. A programmable
// prescaler produces the count tick; the count register runs in one-shot or
// periodic mode and raises a maskable match interrupt against COMPARE.
//
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : timer_ctrl_if.slave (SEL, WE, Addr, Di, Do)
//   IRQ   : interrupt request = MATCH & IE
//   TICK  : one-cycle prescaler tick pulse (combinational)
//
// Register map (word index):
//   0 CTRL     [0] EN, [1] MODE (1 = periodic), [2] IE
//   1 PRESCALE
//   2 COUNT
//   3 COMPARE
//   4 STATUS   [0] MATCH, write-1-to-clear
//   5-7        read 0, writes ignored
// ----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic         CLK,
    input  logic         RESET,
    timer_ctrl_if.slave  bus,
    output logic         IRQ,
    output logic         TICK
);

    localparam logic [31:0] PRESCALE_RST = 32'(CLK_HZ / TICK_HZ - 1);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_COMPARE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    // ctrl_r bit positions
    localparam int EN_BIT   = 0;
    localparam int MODE_BIT = 1;
    localparam int IE_BIT   = 2;

    logic [2:0]  ctrl_r;
    logic [31:0] prescale_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        match_r;
    logic [31:0] pcnt_r;

    logic        wr_s;
    logic        wr_ctrl_s;
    logic        wr_prescale_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        tick_s;
    logic [31:0] count_inc_s;
    logic        hit_s;
    logic [31:0] rdata_s;

    // Write strobes and match detection for the current cycle
    always_comb begin
        wr_s          = bus.SEL & bus.WE;
        wr_ctrl_s     = wr_s && (bus.Addr == ADDR_CTRL);
        wr_prescale_s = wr_s && (bus.Addr == ADDR_PRESCALE);
        wr_count_s    = wr_s && (bus.Addr == ADDR_COUNT);
        wr_compare_s  = wr_s && (bus.Addr == ADDR_COMPARE);
        wr_status_s   = wr_s && (bus.Addr == ADDR_STATUS);
        tick_s        = ctrl_r[EN_BIT] && (pcnt_r == prescale_r);
        count_inc_s   = count_r + 32'd1;
        // A COUNT write on a tick edge overrides the increment, so it also
        // suppresses the match that increment would have produced.
        hit_s         = tick_s && (count_inc_s == compare_r) && !wr_count_s;
    end

    // Prescaler counter: cleared by PRESCALE/COUNT writes, frozen while EN=0
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pcnt_r <= 32'd0;
        end else if (wr_prescale_s || wr_count_s) begin
            pcnt_r <= 32'd0;
        end else if (ctrl_r[EN_BIT]) begin
            pcnt_r <= tick_s ? 32'd0 : (pcnt_r + 32'd1);
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // Control register: software write wins over the one-shot auto-stop
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_r <= 3'd0;
        end else if (wr_ctrl_s) begin
            ctrl_r <= bus.Di[2:0];
        end else if (hit_s && !ctrl_r[MODE_BIT]) begin
            ctrl_r[EN_BIT] <= 1'b0;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // PRESCALE and COMPARE are plain software registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prescale_r <= PRESCALE_RST;
            compare_r  <= 32'd0;
        end else begin
            if (wr_prescale_s) begin
                prescale_r <= bus.Di;
            end else begin
                prescale_r <= prescale_r;
            end
            if (wr_compare_s) begin
                compare_r <= bus.Di;
            end else begin
                compare_r <= compare_r;
            end
        end
    end

    // Count register: periodic mode restarts from 0 on a match, one-shot
    // parks on the COMPARE value
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_r <= 32'd0;
        end else if (wr_count_s) begin
            count_r <= bus.Di;
        end else if (hit_s && ctrl_r[MODE_BIT]) begin
            count_r <= 32'd0;
        end else if (tick_s) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

    // Match flag: a new match beats a simultaneous write-1-to-clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            match_r <= 1'b0;
        end else if (hit_s) begin
            match_r <= 1'b1;
        end else if (wr_status_s && bus.Di[0]) begin
            match_r <= 1'b0;
        end else begin
            match_r <= match_r;
        end
    end

    // Combinational read mux so a load completes in one CPU cycle
    always_comb begin
        rdata_s = 32'd0;
        if (bus.SEL) begin
            case (bus.Addr)
                ADDR_CTRL:     rdata_s = {29'd0, ctrl_r};
                ADDR_PRESCALE: rdata_s = prescale_r;
                ADDR_COUNT:    rdata_s = count_r;
                ADDR_COMPARE:  rdata_s = compare_r;
                ADDR_STATUS:   rdata_s = {31'd0, match_r};
                default:       rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.Do = rdata_s;
    assign IRQ    = match_r & ctrl_r[IE_BIT];
    assign TICK   = tick_s;

endmodule

// File: tb/tb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_ctrl
// Directed scenarios followed by randomized bus traffic, all compared against
// a behavioural register-level model of the timer held in this bench.
// ----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic CLK;
    logic RESET;
    logic IRQ;
    logic TICK;

    timer_ctrl_if bus ();

    timer_ctrl #(.CLK_HZ(50_000_000), .TICK_HZ(1000)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .IRQ   (IRQ),
        .TICK  (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model: the five software-visible registers plus the
    // prescaler position
    logic        m_en, m_mode, m_ie, m_match;
    logic [31:0] m_pre, m_cnt, m_cmp, m_pcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_mode = 1'b0; m_ie = 1'b0; m_match = 1'b0;
        m_pre = 32'd49999; m_cnt = 32'd0; m_cmp = 32'd0; m_pcnt = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic sel, input logic [2:0] a);
        if (!sel) return 32'd0;
        case (a)
            3'd0:    return {29'd0, m_ie, m_mode, m_en};
            3'd1:    return m_pre;
            3'd2:    return m_cnt;
            3'd3:    return m_cmp;
            3'd4:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs, clock, advance model
    task automatic cyc(input logic sel, input logic we, input logic [2:0] a, input logic [31:0] d);
        logic        tick, w, hit;
        logic [31:0] nxt;
        bus.SEL = sel; bus.WE = we; bus.Addr = a; bus.Di = d;
        #2;
        tick = m_en && (m_pcnt == m_pre);
        chk("do",   bus.Do, m_read(sel, a));
        chk("irq",  {31'd0, IRQ},  {31'd0, m_match & m_ie});
        chk("tick", {31'd0, TICK}, {31'd0, tick});
        w   = sel && we;
        nxt = m_cnt + 32'd1;
        hit = tick && (nxt == m_cmp) && !(w && a == 3'd2);
        @(posedge CLK);
        // prescaler position
        if (w && (a == 3'd1 || a == 3'd2)) m_pcnt = 32'd0;
        else if (m_en)                    m_pcnt = tick ? 32'd0 : m_pcnt + 32'd1;
        // count
        if (w && a == 3'd2)      m_cnt = d;
        else if (hit && m_mode)  m_cnt = 32'd0;
        else if (tick)           m_cnt = nxt;
        // match flag
        if (hit)                          m_match = 1'b1;
        else if (w && a == 3'd4 && d[0])  m_match = 1'b0;
        // control (uses the mode in force before this edge)
        if (w && a == 3'd0) begin
            m_en = d[0]; m_mode = d[1]; m_ie = d[2];
        end else if (hit && !m_mode) begin
            m_en = 1'b0;
        end
        if (w && a == 3'd1) m_pre = d;
        if (w && a == 3'd3) m_cmp = d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    // Read a register mid-cycle and compare against a fixed expectation
    task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.SEL = 1'b1; bus.WE = 1'b0; bus.Addr = a; bus.Di = 32'd0;
        #1;
        chk(tag, bus.Do, exp);
    endtask

    int          seq [6] = '{1, 2, 0, 1, 2, 0};
    logic [2:0]  ra;
    logic [31:0] rd;

    initial begin
        bus.SEL = 1'b0; bus.WE = 1'b0; bus.Addr = 3'd0; bus.Di = 32'd0;
        RESET = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Reset values
        peek("rst_prescale", 3'd1, 32'd49999);
        peek("rst_count",    3'd2, 32'd0);
        chk("rst_irq",  {31'd0, IRQ},  32'd0);
        chk("rst_tick", {31'd0, TICK}, 32'd0);
        idle(1);
        peek("rst_ctrl",    3'd0, 32'd0);
        peek("rst_compare", 3'd3, 32'd0);
        peek("rst_status",  3'd4, 32'd0);
        idle(1);

        // Periodic: tick every 5 cycles, COUNT 1,2,0,...
        wr(3'd1, 32'd4);
        wr(3'd3, 32'd3);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'd7);
        for (int k = 0; k < 6; k++) begin
            idle(5);
            peek("per_count", 3'd2, 32'(seq[k]));
            if (k == 1) chk("per_irq_low", {31'd0, IRQ}, 32'd0);
            if (k >= 2) chk("per_irq_high", {31'd0, IRQ}, 32'd1);
        end
        wr(3'd4, 32'd1);
        chk("per_w1c_irq", {31'd0, IRQ}, 32'd0);

        // One-shot: 10 single-cycle ticks, then park on COMPARE
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd10);
        wr(3'd2, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'd5);
        idle(10);
        peek("os_count", 3'd2, 32'd10);
        peek("os_ctrl",  3'd0, 32'd4);
        chk("os_irq",  {31'd0, IRQ},  32'd1);
        chk("os_tick", {31'd0, TICK}, 32'd0);
        idle(2);
        peek("os_hold", 3'd2, 32'd10);
        wr(3'd0, 32'd5);
        idle(1);
        peek("os_restart", 3'd2, 32'd11);

        // Wrap with COMPARE=0
        wr(3'd0, 32'd0);
        wr(3'd2, 32'hFFFF_FFFE);
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'd3);
        idle(1);
        peek("wrap_max", 3'd2, 32'hFFFF_FFFF);
        peek("wrap_nomatch", 3'd4, 32'd0);
        idle(1);
        peek("wrap_zero",  3'd2, 32'd0);
        peek("wrap_match", 3'd4, 32'd1);

        // Collisions
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd8);
        wr(3'd2, 32'd6);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'd3);
        idle(1);
        wr(3'd2, 32'd7);
        peek("col_cnt_wr", 3'd2, 32'd7);
        peek("col_nomatch", 3'd4, 32'd0);
        wr(3'd4, 32'd1);
        peek("col_w1c_set", 3'd4, 32'd1);
        peek("col_periodic", 3'd2, 32'd0);

        // Asynchronous reset between clock edges
        idle(3);
        RESET = 1'b0;
        model_reset();
        peek("ar_prescale", 3'd1, 32'd49999);
        peek("ar_ctrl",     3'd0, 32'd0);
        chk("ar_irq", {31'd0, IRQ}, 32'd0);
        #3;
        RESET = 1'b1;
        idle(3);
        peek("ar_hold", 3'd2, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd1);
        idle(2);
        peek("ar_resume", 3'd2, 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ra = 3'($urandom_range(0, 7));
            case (ra)
                3'd1:    rd = 32'($urandom_range(0, 3));
                3'd2:    rd = 32'($urandom_range(0, 12));
                3'd3:    rd = 32'($urandom_range(0, 12));
                default: rd = $urandom;
            endcase
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), ra, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
